// File: rtl/line_buffer_feeder.sv
// Streams a raster frame through two line buffers and presents one element per
// window row to kernelWidth downstream row feeders, flagging each complete window.
module line_buffer_feeder #(
    parameter  int elementWidth = 4,
    parameter  int kernelWidth  = 3,
    parameter  int maxRowWidth  = 32,
    localparam int CW           = $clog2(maxRowWidth + 1)
) (
    input  logic                                      clk,
    input  logic                                      nrst,
    input  logic                                      start_i,
    input  logic [CW-1:0]                             row_width_i,
    input  logic [15:0]                               num_rows_i,
    input  logic [elementWidth-1:0]                   pixel_i,
    input  logic                                      pixel_valid_i,
    output logic                                      pixel_ready_o,
    output logic [kernelWidth-1:0][elementWidth-1:0]  feature_serial_o,
    output logic                                      load_o,
    output logic                                      window_valid_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      cfg_err_o
);

    localparam int            AW       = $clog2(maxRowWidth);
    localparam logic [CW-1:0] KW_CW    = CW'(kernelWidth);
    localparam logic [CW-1:0] MAX_CW   = CW'(maxRowWidth);
    localparam logic [CW-1:0] ONE_CW   = CW'(1);
    localparam logic [CW-1:0] TWO_CW   = CW'(2);
    localparam logic [15:0]   KW_16    = 16'(kernelWidth);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CW-1:0]           r_row_width;
    logic [15:0]             r_num_rows;
    logic [CW-1:0]           r_col;
    logic [15:0]             r_row;
    logic                    r_win_pend;
    logic [elementWidth-1:0] r_lb0 [maxRowWidth];
    logic [elementWidth-1:0] r_lb1 [maxRowWidth];

    logic                    w_cfg_ok;
    logic                    w_start_ok;
    logic                    w_start_bad;
    logic                    w_accept;
    logic                    w_last_col;
    logic                    w_last_row;
    logic [AW-1:0]           w_idx;

    assign w_cfg_ok    = (row_width_i >= KW_CW) && (row_width_i <= MAX_CW) &&
                         (num_rows_i >= KW_16);
    assign w_start_ok  = (r_state == IDLE) && start_i && w_cfg_ok;
    assign w_start_bad = (r_state == IDLE) && start_i && !w_cfg_ok;
    assign w_accept    = (r_state == STREAM) && pixel_valid_i;
    assign w_last_col  = (r_col == r_row_width - ONE_CW);
    assign w_last_row  = (r_row == r_num_rows - 16'd1);
    assign w_idx       = r_col[AW-1:0];

    always_comb begin
        w_next_state  = r_state;
        pixel_ready_o = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_next_state = STREAM;
            end
            STREAM: begin
                pixel_ready_o = 1'b1;
                busy_o        = 1'b1;
                if (w_accept && w_last_col && w_last_row) w_next_state = DONE;
            end
            DONE: begin
                busy_o       = 1'b1;
                done_o       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state          <= IDLE;
            r_row_width      <= '0;
            r_num_rows       <= '0;
            r_col            <= '0;
            r_row            <= '0;
            r_win_pend       <= 1'b0;
            feature_serial_o <= '0;
            load_o           <= 1'b0;
            window_valid_o   <= 1'b0;
            cfg_err_o        <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            cfg_err_o      <= w_start_bad;
            load_o         <= w_accept;
            // A window completes once the row feeders hold three columns of three rows.
            r_win_pend     <= w_accept && (r_row >= 16'd2) && (r_col >= TWO_CW);
            window_valid_o <= r_win_pend;
            if (w_start_ok) begin
                r_row_width <= row_width_i;
                r_num_rows  <= num_rows_i;
                r_col       <= '0;
                r_row       <= '0;
            end
            if (w_accept) begin
                feature_serial_o[0] <= (r_row >= 16'd2) ? r_lb0[w_idx] : '0;
                feature_serial_o[1] <= (r_row != 16'd0) ? r_lb1[w_idx] : '0;
                feature_serial_o[2] <= pixel_i;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + ONE_CW;
                end
            end
        end
    end

    // Buffers are never cleared; row-index masking hides stale contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_idx] <= r_lb1[w_idx];
            r_lb1[w_idx] <= pixel_i;
        end
    end

endmodule
